// File: rtl/lfsr_rr_dispenser.sv
// Purpose: shared 16-bit XNOR LFSR that hands one fresh word to a round-robin granted requester.
// Latency: req sampled at edge k shows up as gnt/rnd_data right after edge k (1 cycle).
// Backpressure: none; requests are level-held and stay pending until granted, at most one grant per cycle.
//
// Ports:
//   clk        system clock, rising edge
//   rst_b      asynchronous active-low reset
//   seed_load  single-cycle pulse, loads seed_val (16'hFFFF is replaced by SEED)
//   seed_val   seed value sampled with seed_load
//   req        level request per consumer
//   gnt        registered one-hot grant pulse
//   rnd_data   registered random word, updated only on a grant edge or reset
//   busy       high while the post-seed warm-up is running
module lfsr_rr_dispenser #(
  parameter int          NUM_REQ = 4,
  parameter logic [15:0] SEED    = 16'hABCD,
  parameter int          WARMUP  = 16
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               seed_load,
  input  logic [15:0]        seed_val,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [15:0]        rnd_data,
  output logic               busy
);

  localparam int              PW       = $clog2(NUM_REQ);
  localparam logic [PW-1:0]   LAST_IDX = PW'(NUM_REQ - 1);
  localparam logic [7:0]      WU_LAST  = (WARMUP == 0) ? 8'd0 : 8'(WARMUP - 1);
  localparam bit              WU_NONE  = (WARMUP == 0);

  typedef enum logic {
    ST_WARMUP,
    ST_SERVE
  } state_t;

  // With no warm-up configured the block comes straight out of reset/seed into SERVE.
  localparam state_t ST_INIT = WU_NONE ? ST_SERVE : ST_WARMUP;

  state_t             state, state_nxt;
  logic [15:0]        lfsr, lfsr_nxt;
  logic [7:0]         cnt;
  logic [PW-1:0]      ptr, ptr_nxt;
  logic [PW-1:0]      gidx;
  logic               found;
  logic               do_step;
  logic               do_grant;
  logic [15:0]        seed_eff;
  logic [NUM_REQ-1:0] gnt_vec;

  // LFSR step: shift left with the old MSB fed back into bit 0 and XNORed into taps 4, 13, 15.
  always_comb begin
    lfsr_nxt     = {lfsr[14:0], lfsr[15]};
    lfsr_nxt[4]  = lfsr[3]  ~^ lfsr[15];
    lfsr_nxt[13] = lfsr[12] ~^ lfsr[15];
    lfsr_nxt[15] = lfsr[14] ~^ lfsr[15];
  end

  // All-ones is the XNOR lock-up state, so it is never allowed in as a seed.
  assign seed_eff = (seed_val == 16'hFFFF) ? SEED : seed_val;

  // Round-robin search: first pass covers ptr..NUM_REQ-1, second pass wraps to 0..ptr-1.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (PW'(i) >= ptr)) begin
        found = 1'b1;
        gidx  = PW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (PW'(i) < ptr)) begin
        found = 1'b1;
        gidx  = PW'(i);
      end
    end
  end

  assign ptr_nxt = (gidx == LAST_IDX) ? '0 : gidx + PW'(1);
  assign gnt_vec = {{(NUM_REQ-1){1'b0}}, 1'b1} << gidx;

  // Next-state / step control. A seed load overrides everything else that cycle.
  always_comb begin
    state_nxt = state;
    do_step   = 1'b0;
    do_grant  = 1'b0;
    if (seed_load) begin
      state_nxt = ST_INIT;
    end else begin
      case (state)
        ST_WARMUP: begin
          do_step = 1'b1;
          if (cnt == WU_LAST) begin
            state_nxt = ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (found) begin
            do_grant = 1'b1;
            do_step  = 1'b1;
          end
        end
        default: state_nxt = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      lfsr     <= SEED;
      cnt      <= 8'd0;
      ptr      <= '0;
      gnt      <= '0;
      rnd_data <= 16'h0000;
    end else begin
      gnt <= '0;
      if (seed_load) begin
        lfsr <= seed_eff;
        cnt  <= 8'd0;
      end else if (do_step) begin
        lfsr <= lfsr_nxt;
        if (state == ST_WARMUP) begin
          cnt <= cnt + 8'd1;
        end
      end
      // The granted word is the pre-step LFSR value, so consecutive grants see consecutive states.
      if (do_grant) begin
        gnt      <= gnt_vec;
        rnd_data <= lfsr;
        ptr      <= ptr_nxt;
      end
    end
  end

  assign busy = (state == ST_WARMUP);

endmodule

// File: tb/tb_lfsr_rr_dispenser.sv
// Bench for lfsr_rr_dispenser: two instances (WARMUP=0 and WARMUP=16) share one stimulus stream.
// A behavioural model predicts each edge's outcome and queues it; a negedge monitor pops and compares.
module tb_lfsr_rr_dispenser;

  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          seed_load;
  logic [15:0]   seed_val;
  logic [NR-1:0] req;
  logic [NR-1:0] gnt0, gnt1;
  logic [15:0]   rnd0, rnd1;
  logic          busy0, busy1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lfsr_rr_dispenser #(.NUM_REQ(NR), .SEED(16'hABCD), .WARMUP(0)) u_dut_w0 (
    .clk(clk), .rst_b(rst_b), .seed_load(seed_load), .seed_val(seed_val),
    .req(req), .gnt(gnt0), .rnd_data(rnd0), .busy(busy0)
  );

  lfsr_rr_dispenser #(.NUM_REQ(NR), .SEED(16'hABCD), .WARMUP(16)) u_dut_w16 (
    .clk(clk), .rst_b(rst_b), .seed_load(seed_load), .seed_val(seed_val),
    .req(req), .gnt(gnt1), .rnd_data(rnd1), .busy(busy1)
  );

  typedef struct packed {
    logic [31:0]   tag;
    logic [NR-1:0] gnt;
    logic [15:0]   rnd;
    logic          busy;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model state per instance: warm-up edges still to run, pointer, current word.
  logic [15:0]   m_lfsr[2];
  logic [15:0]   m_rnd[2];
  logic [NR-1:0] m_gnt[2];
  int            m_left[2];
  int            m_ptr[2];

  function automatic int wu(input int d);
    return (d == 0) ? 0 : 16;
  endfunction

  // Plain shift with feedback into bit 0; when the feedback bit is 0 the XNOR taps invert.
  function automatic logic [15:0] ref_next(input logic [15:0] s);
    logic [15:0] n;
    n = {s[14:0], s[15]};
    if (!s[15]) n = n ^ 16'hA010;
    return n;
  endfunction

  task automatic model_reset(input int d);
    m_lfsr[d] = 16'hABCD;
    m_rnd[d]  = 16'h0000;
    m_gnt[d]  = '0;
    m_left[d] = wu(d);
    m_ptr[d]  = 0;
  endtask

  task automatic model_edge(input int d);
    bit done;
    done     = 1'b0;
    m_gnt[d] = '0;
    if (!rst_b) begin
      model_reset(d);
    end else if (seed_load) begin
      m_lfsr[d] = (seed_val == 16'hFFFF) ? 16'hABCD : seed_val;
      m_left[d] = wu(d);
    end else if (m_left[d] > 0) begin
      m_lfsr[d] = ref_next(m_lfsr[d]);
      m_left[d] = m_left[d] - 1;
    end else begin
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (m_ptr[d] + k) % NR;
        if (!done && req[i]) begin
          done        = 1'b1;
          m_gnt[d][i] = 1'b1;
          m_rnd[d]    = m_lfsr[d];
          m_lfsr[d]   = ref_next(m_lfsr[d]);
          m_ptr[d]    = (i + 1) % NR;
        end
      end
    end
  endtask

  task automatic apply(input logic [NR-1:0] r, input logic sl, input logic [15:0] sv);
    exp_t e;
    req       = r;
    seed_load = sl;
    seed_val  = sv;
    for (int d = 0; d < 2; d++) begin
      model_edge(d);
      e.tag  = 32'(cyc + 1);
      e.gnt  = m_gnt[d];
      e.rnd  = m_rnd[d];
      e.busy = (m_left[d] > 0);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic drive(input logic [NR-1:0] r, input logic sl, input logic [15:0] sv);
    apply(r, sl, sv);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mon(input int d, input logic [NR-1:0] g, input logic [15:0] r, input logic b);
    exp_t e;
    bit   have;
    have = 1'b0;
    if (d == 0) begin
      while (q0.size() > 0 && q0[0].tag < 32'(cyc)) begin
        e = q0.pop_front();
        checks++; errors++;
        $display("FAIL dut%0d stale_record tag %0d at cycle %0d", d, e.tag, cyc);
      end
      if (q0.size() > 0 && q0[0].tag == 32'(cyc)) begin e = q0.pop_front(); have = 1'b1; end
    end else begin
      while (q1.size() > 0 && q1[0].tag < 32'(cyc)) begin
        e = q1.pop_front();
        checks++; errors++;
        $display("FAIL dut%0d stale_record tag %0d at cycle %0d", d, e.tag, cyc);
      end
      if (q1.size() > 0 && q1[0].tag == 32'(cyc)) begin e = q1.pop_front(); have = 1'b1; end
    end
    if (have) begin
      checks++;
      if (g !== e.gnt || r !== e.rnd || b !== e.busy) begin
        errors++;
        $display("FAIL dut%0d edge_output cyc %0d: gnt=%b rnd=%h busy=%b, expected gnt=%b rnd=%h busy=%b",
                 d, cyc, g, r, b, e.gnt, e.rnd, e.busy);
      end
    end else if (g !== '0) begin
      checks++; errors++;
      $display("FAIL dut%0d unexpected_gnt cyc %0d: gnt=%b, expected 0", d, cyc, g);
    end
  endtask

  always @(negedge clk) begin
    mon(0, gnt0, rnd0, busy0);
    mon(1, gnt1, rnd1, busy1);
  end

  logic [NR-1:0] rr_seq [5];

  initial begin
    rst_b     = 1'b0;
    req       = '0;
    seed_load = 1'b0;
    seed_val  = 16'h0000;
    model_reset(0);
    model_reset(1);
    repeat (2) @(posedge clk);
    #1;

    // Reset values.
    chk("rst_gnt0",  32'(gnt0),  32'h0);
    chk("rst_rnd0",  32'(rnd0),  32'h0);
    chk("rst_busy0", 32'(busy0), 32'h0);
    chk("rst_gnt1",  32'(gnt1),  32'h0);
    chk("rst_rnd1",  32'(rnd1),  32'h0);
    chk("rst_busy1", 32'(busy1), 32'h1);
    rst_b = 1'b1;

    // First words from SEED; warm-up instance stays quiet.
    drive(4'b0001, 1'b0, 16'h0);
    chk("kat_word1", 32'(rnd0), 32'hABCD);
    drive(4'b0001, 1'b0, 16'h0);
    chk("kat_word2", 32'(rnd0), 32'h579B);
    drive(4'b0001, 1'b0, 16'h0);
    chk("kat_word3", 32'(rnd0), 32'h0F26);

    // req[2] held: warm-up lasts exactly 16 edges, first grant at edge 17.
    for (int e = 4; e <= 15; e++) drive(4'b0100, 1'b0, 16'h0);
    chk("wu_busy_e15", 32'(busy1), 32'h1);
    chk("wu_gnt_e15",  32'(gnt1),  32'h0);
    drive(4'b0100, 1'b0, 16'h0);
    chk("wu_busy_e16", 32'(busy1), 32'h0);
    chk("wu_gnt_e16",  32'(gnt1),  32'h0);
    drive(4'b0100, 1'b0, 16'h0);
    chk("wu_gnt_e17",  32'(gnt1),  32'h4);

    // Full and sparse request patterns.
    repeat (5) drive(4'b1111, 1'b0, 16'h0);
    repeat (4) drive(4'b1010, 1'b0, 16'h0);

    // Illegal seed substitution and a legal seed.
    drive(4'b0000, 1'b1, 16'hFFFF);
    drive(4'b0010, 1'b0, 16'h0);
    chk("seed_ffff_word", 32'(rnd0), 32'hABCD);
    drive(4'b0000, 1'b1, 16'h579B);
    drive(4'b0010, 1'b0, 16'h0);
    chk("seed_579b_word", 32'(rnd0), 32'h579B);

    // seed_load beats req in the same cycle.
    drive(4'b0001, 1'b1, 16'h1234);
    chk("seed_vs_req_gnt0",  32'(gnt0),  32'h0);
    chk("seed_vs_req_busy1", 32'(busy1), 32'h1);
    drive(4'b0001, 1'b0, 16'h0);
    chk("seed_vs_req_word", 32'(rnd0), 32'h1234);
    chk("seed_vs_req_gnt",  32'(gnt0), 32'h1);

    // Randomized traffic with occasional reseeds.
    for (int n = 0; n < 400; n++) begin
      logic [NR-1:0] r;
      logic          sl;
      logic [15:0]   sv;
      r  = NR'($urandom_range(0, 15));
      sl = ($urandom_range(0, 31) == 0);
      sv = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      drive(r, sl, sv);
    end

    // Asynchronous reset in the middle of a grant stream.
    repeat (3) drive(4'b1111, 1'b0, 16'h0);
    apply(4'b1111, 1'b0, 16'h0);
    #2;
    rst_b = 1'b0;
    q0.delete();
    q1.delete();
    model_reset(0);
    model_reset(1);
    #1;
    chk("arst_gnt0",  32'(gnt0),  32'h0);
    chk("arst_rnd0",  32'(rnd0),  32'h0);
    chk("arst_busy0", 32'(busy0), 32'h0);
    chk("arst_gnt1",  32'(gnt1),  32'h0);
    chk("arst_busy1", 32'(busy1), 32'h1);
    @(posedge clk);
    #1;
    drive(4'b1111, 1'b0, 16'h0);
    rst_b = 1'b1;
    rr_seq[0] = 4'b0001;
    rr_seq[1] = 4'b0010;
    rr_seq[2] = 4'b0100;
    rr_seq[3] = 4'b1000;
    rr_seq[4] = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      drive(4'b1111, 1'b0, 16'h0);
      chk($sformatf("rr_after_rst_%0d", k), 32'(gnt0), 32'(rr_seq[k]));
      if (k == 0) chk("rr_after_rst_word", 32'(rnd0), 32'hABCD);
    end

    drive(4'b0000, 1'b0, 16'h0);
    drive(4'b0000, 1'b0, 16'h0);
    @(negedge clk);
    #1;
    chk("q0_drained", 32'(q0.size()), 32'h0);
    chk("q1_drained", 32'(q1.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lfsr_rr_dispenser.md
# lfsr_rr_dispenser

Shared random-number dispenser that owns a 16-bit XNOR LFSR and hands out one fresh word per grant. Up to NUM_REQ consumers request words, for example dither, test-pattern and jitter logic in the sleep-apnea signal path. A round-robin arbiter serves them. The block also sequences seeding and a post-seed warm-up, so no consumer sees an unmixed seed.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- SEED, 16'hABCD: LFSR value at reset. It is also the substitute for an illegal seed.
- WARMUP, 16: LFSR steps after reset or seed load before any grant, 0..255. A value of 0 means no warm-up.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_b  in  1  asynchronous, active-low reset.
- seed_load  in  1  single-cycle pulse that loads seed_val.
- seed_val  in  16  new seed; sampled when seed_load=1.
- req  in  NUM_REQ  level request per consumer.
- gnt  out  NUM_REQ  one-hot grant, registered, 1-cycle pulse.
- rnd_data  out  16  random word, registered; valid in the cycle gnt is high and held until the next grant.
- busy  out  1  high while in WARMUP.

## Operation
- LFSR step next(s), with fb = s[15]:
  - n[0] = fb
  - n[4] = s[3] XNOR fb
  - n[13] = s[12] XNOR fb
  - n[15] = s[14] XNOR fb
  - every other n[i] = s[i-1]
- The lock-up state is 16'hFFFF. A seed_val of 16'hFFFF loads SEED instead.
- States:
  - WARMUP: the LFSR steps every cycle and cnt increments. No grants are issued. When cnt == WARMUP-1 at an edge, go to SERVE and clear busy.
  - SERVE: if any req bit is high, grant exactly one requester. At that edge, rnd_data <= lfsr, lfsr <= next(lfsr), and the gnt bit pulses. If no req is high, the LFSR holds.
- Round-robin:
  - ptr names the highest-priority index; the search runs ptr, ptr+1, …, wrapping modulo NUM_REQ.
  - After granting i, ptr <= (i+1) mod NUM_REQ. After granting NUM_REQ-1, ptr wraps to 0.
- Requests are level-sensitive.
  - A requester keeping req high after its gnt is treated as requesting again; it waits its turn.
  - Requests raised during WARMUP stay pending and are served in SERVE.
- seed_load in any state:
  - At that edge: lfsr <= seed (or SEED if the seed is FFFF), cnt <= 0, ptr unchanged.
  - State becomes WARMUP (busy=1), or stays in SERVE if WARMUP == 0.
  - seed_load wins over req in the same cycle: no grant, and no LFSR step beyond the load.
- Reset, asynchronous, including mid-operation:
  - lfsr = SEED, cnt = 0, ptr = 0, gnt = 0, rnd_data = 16'h0000.
  - state = WARMUP and busy = 1, or SERVE and busy = 0 when WARMUP == 0.
  - Any grant in flight is dropped.

## Timing
- Grant latency: req high before edge k in SERVE gives gnt and rnd_data visible after edge k (1 cycle).
- Throughput: at most one grant per cycle. With all NUM_REQ requesting continuously, each requester gets one grant every NUM_REQ cycles.
- Warm-up: after rst_b deassertion or a seed_load edge, busy stays high for exactly WARMUP edges. The first grant is possible at edge WARMUP+1.
- gnt is never high while busy=1, nor in the cycle after a seed_load edge.
- Consecutive grants carry consecutive LFSR states. No state is skipped or reused between grants.
- rnd_data changes only on a grant edge or on reset.

## Test plan
- WARMUP=0, reset release, req=4'b0001 for 2 cycles: gnt[0] pulses on 2 edges, with rnd_data = 16'hABCD then 16'h579B. A third grant yields 16'h0F26.
- WARMUP=0, req=4'b1111 held: gnt = 0001, 0010, 0100, 1000, 0001 on consecutive edges (wrap-around). req=4'b1010 held afterward alternates 0010/1000.
- WARMUP=16, req[2] high from reset: busy=1 for 16 edges, and gnt[2] first pulses at edge 17. No gnt before that.
- seed_load with seed_val=16'hFFFF, WARMUP=0, then req[1]: rnd_data = 16'hABCD. With seed_val=16'h579B the first word is 16'h579B.
- seed_load and req[0] in the same cycle: no gnt that edge. The next-edge grant returns the loaded seed (WARMUP=0), or busy rises (WARMUP>0).
- rst_b pulsed low mid-grant with req=4'b1111: gnt and rnd_data are 0 immediately. After release, grant order restarts at index 0 and the first word is 16'hABCD (WARMUP=0).
